ps2_keycode_source: RTL

//  Receives PS/2 scan-code set 2 frames from the keyboard and produces the 8-bit HID-usage keycode

---
 rtl/ps2_keycode_source.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keycode_source.sv
// PS/2 set-2 keyboard receiver: filters the PS/2 clock, deframes 11-bit frames and
// turns make/break sequences into a held HID-usage keycode level.
module ps2_keycode_source #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_press,
    output logic       frame_err,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} pfx_state_e;

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           fclk_q;
    logic [FCW-1:0] fcnt_q;
    logic           fclk_flip_c, fall_c;
    logic [3:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           par_q;
    logic [TCW-1:0] to_cnt_q;
    logic           bv_q, err1_q;
    logic [7:0]     bd_q;

    pfx_state_e     state_q, state_d;
    logic [7:0]     keycode_q, keycode_d;
    logic [8:0]     held_q, held_d;
    logic           held_vld_q, held_vld_d;
    logic           kp_q, kp_d;
    logic           ferr_q;
    logic           ev_make_c, ev_break_c, ev_ext_c;
    logic [7:0]     hid_c;

    function automatic logic [7:0] hid_map(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h05A:  return 8'h28;
            9'h01D:  return 8'h1A;
            9'h01B:  return 8'h16;
            9'h01C:  return 8'h04;
            9'h023:  return 8'h07;
            9'h029:  return 8'h2C;
            9'h076:  return 8'h29;
            9'h175:  return 8'h52;
            9'h172:  return 8'h51;
            9'h16B:  return 8'h50;
            9'h174:  return 8'h4F;
            default: return 8'h00;
        endcase
    endfunction

    // Two-flop synchronisers; pins idle high
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered clock flips on the FILTER_LEN-th consecutive differing sample
    assign fclk_flip_c = (clk_s2_q != fclk_q) && (fcnt_q == FCW'(FILTER_LEN - 1));
    assign fall_c      = fclk_flip_c && fclk_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fclk_q <= 1'b1;
            fcnt_q <= '0;
        end else if (clk_s2_q == fclk_q) begin
            fcnt_q <= '0;
        end else if (fclk_flip_c) begin
            fclk_q <= ~fclk_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + FCW'(1);
        end
    end

    // Frame deserialiser with inter-edge timeout
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            bv_q      <= 1'b0;
            bd_q      <= '0;
            err1_q    <= 1'b0;
        end else begin
            bv_q   <= 1'b0;
            err1_q <= 1'b0;
            if (fall_c) begin
                to_cnt_q <= '0;
                if (bit_cnt_q == 4'd0) begin
                    if (dat_s2_q) err1_q <= 1'b1;
                    else          bit_cnt_q <= 4'd1;
                end else if (bit_cnt_q <= 4'd8) begin
                    shift_q   <= {dat_s2_q, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end else if (bit_cnt_q == 4'd9) begin
                    par_q     <= dat_s2_q;
                    bit_cnt_q <= 4'd10;
                end else begin
                    bit_cnt_q <= '0;
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        bv_q <= 1'b1;
                        bd_q <= shift_q;
                    end else begin
                        err1_q <= 1'b1;
                    end
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (to_cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt_q <= '0;
                    to_cnt_q  <= '0;
                    err1_q    <= 1'b1;
                end else begin
                    to_cnt_q <= to_cnt_q + TCW'(1);
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            keycode_q  <= '0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            kp_q       <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            keycode_q  <= keycode_d;
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
            kp_q       <= kp_d;
            ferr_q     <= err1_q;
        end
    end

    // Prefix decoding and held-key tracking
    always_comb begin
        state_d    = state_q;
        keycode_d  = keycode_q;
        held_d     = held_q;
        held_vld_d = held_vld_q;
        kp_d       = 1'b0;
        ev_make_c  = 1'b0;
        ev_break_c = 1'b0;
        ev_ext_c   = 1'b0;
        hid_c      = '0;
        if (err1_q) begin
            state_d = ST_IDLE;
        end else if (bv_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (bd_q == 8'hE0)      state_d = ST_EXT;
                    else if (bd_q == 8'hF0) state_d = ST_BRK;
                    else                    ev_make_c = 1'b1;
                end
                ST_EXT: begin
                    if (bd_q == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d   = ST_IDLE;
                        ev_make_c = 1'b1;
                        ev_ext_c  = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d    = ST_IDLE;
                    ev_break_c = 1'b1;
                end
                default: begin
                    state_d    = ST_IDLE;
                    ev_break_c = 1'b1;
                    ev_ext_c   = 1'b1;
                end
            endcase
            hid_c = hid_map(ev_ext_c, bd_q);
            if (ev_make_c && (hid_c != 8'h00)) begin
                keycode_d  = hid_c;
                held_d     = {ev_ext_c, bd_q};
                held_vld_d = 1'b1;
                kp_d       = (hid_c != keycode_q);
            end
            if (ev_break_c && held_vld_q && (held_q == {ev_ext_c, bd_q})) begin
                keycode_d  = '0;
                held_d     = '0;
                held_vld_d = 1'b0;
            end
        end
    end

    assign keycode    = keycode_q;
    assign key_press  = kp_q;
    assign frame_err  = ferr_q;
    assign byte_valid = bv_q;
    assign byte_data  = bd_q;

endmodule
